// File: rtl/traffic_light_ctrl_if.sv
// Signals between the intersection phase controller and its surroundings (tick source, button, walk display, lamps).
// The master side is the controller; the slave side is everything around it.
interface traffic_light_ctrl_if;
  logic       tick_1hz;
  logic       ped_btn;
  logic       walk_done;
  logic       walk_start;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ped_req_led;
  logic [2:0] phase;

  modport master (
    input  tick_1hz, ped_btn, walk_done,
    output walk_start, ns_light, ew_light, ped_req_led, phase
  );

  modport slave (
    output tick_1hz, ped_btn, walk_done,
    input  walk_start, ns_light, ew_light, ped_req_led, phase
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection phase sequencer with a debounced pedestrian request and a walk phase.
// Lamps decode straight from the state register; walk_start is registered. There is no backpressure.
module traffic_light_ctrl #(
  parameter int GREEN_SECS        = 8,
  parameter int YELLOW_SECS       = 3,
  parameter int ALLRED_SECS       = 1,
  parameter int WALK_TIMEOUT_SECS = 15,
  parameter int DEBOUNCE_CYCLES   = 1_000_000
) (
  input logic                  clk,
  input logic                  rst_n,
  traffic_light_ctrl_if.master bus
);
  localparam int MAX_A    = (GREEN_SECS > YELLOW_SECS) ? GREEN_SECS : YELLOW_SECS;
  localparam int MAX_B    = (ALLRED_SECS > WALK_TIMEOUT_SECS) ? ALLRED_SECS : WALK_TIMEOUT_SECS;
  localparam int MAX_SECS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = $clog2(MAX_SECS + 1);
  localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5,
    WALK  = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            dir_ew, dir_ew_nxt;
  logic            enter_walk;
  logic            ped_req;
  logic            walk_start_q;
  logic            sync1, sync2, deb;
  logic [DW-1:0]   deb_cnt;
  logic            deb_rise;

  function automatic logic [CW-1:0] dur_of(state_t s);
    case (s)
      NS_G, EW_G: dur_of = CW'(GREEN_SECS);
      NS_Y, EW_Y: dur_of = CW'(YELLOW_SECS);
      WALK:       dur_of = CW'(WALK_TIMEOUT_SECS);
      default:    dur_of = CW'(ALLRED_SECS);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RED_B;
      cnt          <= CW'(ALLRED_SECS);
      dir_ew       <= 1'b0;
      walk_start_q <= 1'b0;
      ped_req      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      dir_ew       <= dir_ew_nxt;
      walk_start_q <= enter_walk;
      // Entering WALK swallows a request that debounces on the same edge.
      if (enter_walk)
        ped_req <= 1'b0;
      else if (deb_rise)
        ped_req <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dir_ew_nxt = dir_ew;
    enter_walk = 1'b0;
    case (state)
      WALK: begin
        if (bus.walk_done || (bus.tick_1hz && cnt == CNT_ONE)) begin
          state_nxt = dir_ew ? EW_G : NS_G;
          cnt_nxt   = CW'(GREEN_SECS);
        end else if (bus.tick_1hz) begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      NS_G, NS_Y, RED_A, EW_G, EW_Y, RED_B: begin
        if (bus.tick_1hz) begin
          if (cnt == CNT_ONE) begin
            case (state)
              NS_G:    state_nxt = NS_Y;
              NS_Y:    state_nxt = RED_A;
              RED_A:   state_nxt = EW_G;
              EW_G:    state_nxt = EW_Y;
              EW_Y:    state_nxt = RED_B;
              default: state_nxt = NS_G;
            endcase
            if ((state == RED_A || state == RED_B) && ped_req) begin
              dir_ew_nxt = (state == RED_A);
              state_nxt  = WALK;
              enter_walk = 1'b1;
            end
            cnt_nxt = dur_of(state_nxt);
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt = RED_B;
        cnt_nxt   = CW'(ALLRED_SECS);
      end
    endcase
  end

  always_comb begin
    bus.ns_light = 3'b100;
    bus.ew_light = 3'b100;
    case (state)
      NS_G:    bus.ns_light = 3'b001;
      NS_Y:    bus.ns_light = 3'b010;
      EW_G:    bus.ew_light = 3'b001;
      EW_Y:    bus.ew_light = 3'b010;
      default: ;
    endcase
  end

  // The debounce counter only runs while the synced level disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= bus.ped_btn;
      sync2 <= sync1;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign deb_rise        = sync2 && !deb && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign bus.walk_start  = walk_start_q;
  assign bus.ped_req_led = ped_req;
  assign bus.phase       = state;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a phase/tick model checked every cycle, plus directed scenarios with literal expectations.
module tb_traffic_light_ctrl;
  localparam int G  = 3;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int WT = 5;
  localparam int DB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tick_r = 1'b0;
  logic btn_r  = 1'b0;
  logic wd_r   = 1'b0;
  logic tick_rand = 1'b0;
  int   tcnt = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl_if bus();
  assign bus.tick_1hz  = tick_r;
  assign bus.ped_btn   = btn_r;
  assign bus.walk_done = wd_r;

  traffic_light_ctrl #(
    .GREEN_SECS(G), .YELLOW_SECS(Y), .ALLRED_SECS(AR),
    .WALK_TIMEOUT_SECS(WT), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Phase table indexed by phase number: durations, successor, lamp codes.
  int dur_tbl[7]  = '{G, Y, AR, G, Y, AR, WT};
  int next_tbl[6] = '{1, 2, 3, 4, 5, 0};
  int ns_tbl[7]   = '{1, 2, 4, 4, 4, 4, 4};
  int ew_tbl[7]   = '{4, 4, 4, 1, 2, 4, 4};

  int m_ph, m_rem, m_dir, m_req, m_ws, m_deb, m_run, m_s1, m_s2;
  int m_rise, m_enter, m_nxt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 5; m_rem = AR; m_dir = 0; m_req = 0; m_ws = 0;
      m_deb = 0; m_run = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      m_rise  = 0;
      m_enter = 0;
      if (m_s2 != m_deb) begin
        m_run++;
        if (m_run == DB) begin
          m_deb  = m_s2;
          m_run  = 0;
          m_rise = m_deb;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = int'(btn_r);
      if (m_ph == 6) begin
        if (wd_r || (tick_r && m_rem == 1)) begin
          m_ph  = m_dir;
          m_rem = G;
        end else if (tick_r) begin
          m_rem--;
        end
      end else if (tick_r) begin
        if (m_rem == 1) begin
          m_nxt = next_tbl[m_ph];
          if ((m_ph == 2 || m_ph == 5) && m_req != 0) begin
            m_dir   = m_nxt;
            m_ph    = 6;
            m_enter = 1;
          end else begin
            m_ph = m_nxt;
          end
          m_rem = dur_tbl[m_ph];
        end else begin
          m_rem--;
        end
      end
      m_ws = m_enter;
      if (m_enter != 0) m_req = 0;
      else if (m_rise != 0) m_req = 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("phase", int'(bus.phase), m_ph);
      check("ns_light", int'(bus.ns_light), ns_tbl[m_ph]);
      check("ew_light", int'(bus.ew_light), ew_tbl[m_ph]);
      check("walk_start", int'(bus.walk_start), m_ws);
      check("ped_req_led", int'(bus.ped_req_led), m_req);
      check("both_non_red", int'(bus.ns_light != 3'b100 && bus.ew_light != 3'b100), 0);
    end
  end

  always @(negedge clk) begin
    #1;
    if (!tick_rand) begin
      tcnt   = (tcnt + 1) % 10;
      tick_r = (tcnt == 9);
    end else begin
      tick_r = ($urandom_range(0, 5) == 0);
    end
  end

  task automatic wait_ticks(int n);
    repeat (n) @(posedge clk iff tick_r);
    @(negedge clk);
  endtask

  task automatic wait_phase(int p, int budget, string name);
    int k = 0;
    while (int'(bus.phase) != p && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(bus.phase), p);
  endtask

  task automatic press(int n);
    @(negedge clk);
    #2 btn_r = 1'b1;
    repeat (n) @(negedge clk);
    #2 btn_r = 1'b0;
  endtask

  int hold = 0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_phase", int'(bus.phase), 5);
    check("rst_ns", int'(bus.ns_light), 4);
    check("rst_ew", int'(bus.ew_light), 4);
    check("rst_walk_start", int'(bus.walk_start), 0);
    check("rst_led", int'(bus.ped_req_led), 0);
    #1 rst_n = 1'b1;

    // Plain cycle
    wait_ticks(AR); check("seq_ns_g", int'(bus.phase), 0);
    check("seq_ns_g_lamp", int'(bus.ns_light), 1);
    wait_ticks(G);  check("seq_ns_y", int'(bus.phase), 1);
    check("seq_ns_y_lamp", int'(bus.ns_light), 2);
    wait_ticks(Y);  check("seq_red_a", int'(bus.phase), 2);
    wait_ticks(AR); check("seq_ew_g", int'(bus.phase), 3);
    check("seq_ew_g_lamp", int'(bus.ew_light), 1);
    wait_ticks(G);  check("seq_ew_y", int'(bus.phase), 4);
    wait_ticks(Y);  check("seq_red_b", int'(bus.phase), 5);
    wait_ticks(AR); check("seq_ns_g2", int'(bus.phase), 0);

    // Press in NS_G: led rises six edges after the button
    #2 btn_r = 1'b1;
    repeat (5) @(negedge clk);
    check("led_before_debounce", int'(bus.ped_req_led), 0);
    @(negedge clk);
    check("led_after_debounce", int'(bus.ped_req_led), 1);
    repeat (4) @(negedge clk);
    #2 btn_r = 1'b0;
    wait_phase(6, 300, "walk_reached");
    check("walk_start_first", int'(bus.walk_start), 1);
    check("walk_led_cleared", int'(bus.ped_req_led), 0);
    check("walk_lamps", int'(bus.ns_light) * 8 + int'(bus.ew_light), 36);
    @(negedge clk);
    check("walk_start_second", int'(bus.walk_start), 0);

    // walk_done two ticks into WALK
    wait_ticks(2);
    check("walk_still", int'(bus.phase), 6);
    #2 wd_r = 1'b1;
    @(negedge clk);
    check("walk_done_exit", int'(bus.phase), 3);
    check("walk_done_ew", int'(bus.ew_light), 1);
    #2 wd_r = 1'b0;

    // Stray walk_done in NS_G, then walk timeout
    wait_phase(0, 300, "ns_g_again");
    #2 wd_r = 1'b1;
    @(negedge clk);
    #2 wd_r = 1'b0;
    check("stray_walk_done", int'(bus.phase), 0);
    press(10);
    wait_phase(6, 300, "walk2_reached");
    wait_ticks(WT - 1);
    check("walk_before_timeout", int'(bus.phase), 6);
    wait_ticks(1);
    check("walk_timeout_exit", int'(bus.phase), 3);

    // Bouncing button never registers
    @(negedge clk);
    #2;
    for (int i = 0; i < 10; i++) begin
      btn_r = (i % 2 == 0);
      repeat (2) @(negedge clk);
      #2;
    end
    btn_r = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("bounce_led", int'(bus.ped_req_led), 0);
    end

    // Reset mid-WALK with a new request pending
    press(10);
    wait_phase(6, 400, "walk3_reached");
    press(10);
    check("walk_press_led", int'(bus.ped_req_led), 1);
    check("walk_press_phase", int'(bus.phase), 6);
    #1 rst_n = 1'b0;
    #1;
    check("midwalk_rst_ns", int'(bus.ns_light), 4);
    check("midwalk_rst_ew", int'(bus.ew_light), 4);
    check("midwalk_rst_ws", int'(bus.walk_start), 0);
    check("midwalk_rst_led", int'(bus.ped_req_led), 0);
    check("midwalk_rst_phase", int'(bus.phase), 5);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Random traffic against the model
    tick_rand = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #2;
      if (hold == 0) begin
        btn_r = 1'($urandom_range(0, 1));
        hold  = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      wd_r = ($urandom_range(0, 19) == 0);
      if (c == 2000) begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
